// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencing controller: state encoding,
// default widths and the instruction the IF/ID register holds after a flush.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10,
    HALT  = 2'b11
  } fetch_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_CNT_W  = 16;

  // IF/ID register contents after a flush
  localparam logic [15:0] NOP_INSN = 16'h0000;

  function automatic logic is_fetching(input fetch_state_t s);
    return (s == FETCH) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // count register: increments on inc until it reaches all-ones
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: drives IMEM requests, PC advance/hold/redirect,
// IF/ID capture/flush, queues one redirect across a slow access, drains on HLT.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic              stall_id,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              hlt_dec,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  wait_cycles
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic              pend_valid;
  logic              pend_valid_nxt;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pend_target_nxt;
  logic [ADDR_W-1:0] last_target;
  logic              wait_inc;

  // state, queued redirect and last driven target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pend_valid  <= 1'b0;
      pend_target <= {ADDR_W{1'b0}};
      last_target <= {ADDR_W{1'b0}};
    end else begin
      state       <= state_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      last_target <= redirect_target;
    end
  end

  // next state and Mealy outputs; a queued redirect outranks fresh branch/HLT
  always_comb begin
    state_nxt       = state;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    imem_req        = 1'b0;
    pc_en           = 1'b0;
    pc_redirect     = 1'b0;
    redirect_target = last_target;
    ifid_we         = 1'b0;
    ifid_flush      = 1'b0;
    halted          = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (pend_valid) begin
          if (imem_ready) begin
            pc_en           = 1'b1;
            pc_redirect     = 1'b1;
            redirect_target = pend_target;
            ifid_flush      = 1'b1;
            pend_valid_nxt  = 1'b0;
          end else begin
            pend_valid_nxt = 1'b1;
          end
        end else if (br_taken) begin
          if (imem_ready) begin
            pc_en           = 1'b1;
            pc_redirect     = 1'b1;
            redirect_target = br_target;
            ifid_flush      = 1'b1;
          end else begin
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = br_target;
          end
        end else if (hlt_dec) begin
          if (imem_ready) begin
            ifid_flush = 1'b1;
            state_nxt  = HALT;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (imem_ready && !stall_id) begin
          pc_en   = 1'b1;
          ifid_we = 1'b1;
        end else begin
          pc_en = 1'b0;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ifid_flush = 1'b1;
          state_nxt  = HALT;
        end else begin
          state_nxt = DRAIN;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign wait_inc = is_fetching(state) && imem_req && !imem_ready;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .inc  (wait_inc),
    .count(wait_cycles)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: behavioural model checked every cycle plus
// hand-computed pinned expectations for each scenario.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic        stall_id = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        hlt_dec = 1'b0;
  logic        pc_en;
  logic        pc_redirect;
  logic [15:0] redirect_target;
  logic        ifid_we;
  logic        ifid_flush;
  logic        halted;
  logic [3:0]  wait_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.ADDR_W(16), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_ready     (imem_ready),
    .stall_id       (stall_id),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .hlt_dec        (hlt_dec),
    .pc_en          (pc_en),
    .pc_redirect    (pc_redirect),
    .redirect_target(redirect_target),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .halted         (halted),
    .wait_cycles    (wait_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        req;
    logic        en;
    logic        redir;
    logic        we;
    logic        flush;
    logic        hlt;
    logic [15:0] tgt;
  } exp_t;

  bit          m_booted = 1'b0;
  bit          m_drain  = 1'b0;
  bit          m_halt   = 1'b0;
  logic [15:0] m_pend[$];
  logic [15:0] m_last_tgt = 16'h0000;
  int          m_waits = 0;

  function automatic exp_t model_eval();
    exp_t e;
    e     = '0;
    e.tgt = m_last_tgt;
    if (!rst_n || !m_booted) begin
      e.req = 1'b0;
    end else if (m_halt) begin
      e.hlt = 1'b1;
    end else begin
      e.req = 1'b1;
      if (m_drain) begin
        e.flush = imem_ready;
      end else if (m_pend.size() != 0) begin
        if (imem_ready) begin
          e.en = 1'b1; e.redir = 1'b1; e.flush = 1'b1; e.tgt = m_pend[0];
        end
      end else if (br_taken) begin
        if (imem_ready) begin
          e.en = 1'b1; e.redir = 1'b1; e.flush = 1'b1; e.tgt = br_target;
        end
      end else if (hlt_dec) begin
        e.flush = imem_ready;
      end else if (imem_ready && !stall_id) begin
        e.en = 1'b1; e.we = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_update(input exp_t e);
    if (e.redir) m_last_tgt = e.tgt;
    if (e.req && !imem_ready && m_waits < 15) m_waits++;
    if (m_booted && !m_halt) begin
      if (m_drain) begin
        if (imem_ready) begin m_halt = 1'b1; m_drain = 1'b0; end
      end else if (m_pend.size() != 0) begin
        if (imem_ready) m_pend.delete();
      end else if (br_taken) begin
        if (!imem_ready) m_pend.push_back(br_target);
      end else if (hlt_dec) begin
        if (imem_ready) m_halt = 1'b1;
        else m_drain = 1'b1;
      end
    end
    m_booted = 1'b1;
  endtask

  // compare DUT to model mid-cycle, then advance the model across the next edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_booted = 1'b0; m_drain = 1'b0; m_halt = 1'b0;
      m_pend.delete(); m_last_tgt = 16'h0000; m_waits = 0;
    end
    e = model_eval();
    check("imem_req",        {31'd0, imem_req},    {31'd0, e.req});
    check("pc_en",           {31'd0, pc_en},       {31'd0, e.en});
    check("pc_redirect",     {31'd0, pc_redirect}, {31'd0, e.redir});
    check("ifid_we",         {31'd0, ifid_we},     {31'd0, e.we});
    check("ifid_flush",      {31'd0, ifid_flush},  {31'd0, e.flush});
    check("halted",          {31'd0, halted},      {31'd0, e.hlt});
    check("redirect_target", {16'd0, redirect_target}, {16'd0, e.tgt});
    check("wait_cycles",     {28'd0, wait_cycles}, m_waits);
    if (rst_n) model_update(e);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rdy, input logic stl, input logic br,
                       input logic [15:0] tgt, input logic hlt);
    @(posedge clk); #1;
    imem_ready = rdy; stall_id = stl; br_taken = br; br_target = tgt; hlt_dec = hlt;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ready = 1'b0; stall_id = 1'b0; br_taken = 1'b0; br_target = 16'h0000; hlt_dec = 1'b0;
    @(negedge clk); #1;
    check("rst_req",   {31'd0, imem_req},  32'd0);
    check("rst_pc_en", {31'd0, pc_en},     32'd0);
    check("rst_halt",  {31'd0, halted},    32'd0);
    check("rst_wait",  {28'd0, wait_cycles}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // boot: BOOT cycle has no request, then streaming fetch
    imem_ready = 1'b1;
    @(negedge clk); #1;
    check("boot_req0", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      check("stream_req", {31'd0, imem_req}, 32'd1);
      check("stream_en",  {31'd0, pc_en},    32'd1);
      check("stream_we",  {31'd0, ifid_we},  32'd1);
    end

    // zero-wait redirect
    drive(1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
    check("zw_redir", {31'd0, pc_redirect}, 32'd1);
    check("zw_tgt",   {16'd0, redirect_target}, 32'h0040);
    check("zw_flush", {31'd0, ifid_flush}, 32'd1);
    check("zw_we",    {31'd0, ifid_we}, 32'd0);

    // stall holds; stall does not block a branch
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    check("stall_en", {31'd0, pc_en}, 32'd0);
    check("stall_we", {31'd0, ifid_we}, 32'd0);
    check("stall_tgt_hold", {16'd0, redirect_target}, 32'h0040);
    drive(1'b1, 1'b1, 1'b1, 16'h0008, 1'b0);
    check("stallbr_redir", {31'd0, pc_redirect}, 32'd1);
    check("stallbr_en",    {31'd0, pc_en}, 32'd1);
    check("stallbr_tgt",   {16'd0, redirect_target}, 32'h0008);

    // HLT with branch: branch wins, no halt
    drive(1'b1, 1'b0, 1'b1, 16'h0020, 1'b1);
    check("hltbr_tgt", {16'd0, redirect_target}, 32'h0020);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("hltbr_nohalt", {31'd0, halted}, 32'd0);
    check("hltbr_en",     {31'd0, pc_en}, 32'd1);

    // redirect queued during a 3-cycle wait; second branch ignored
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
    check("rw_en0", {31'd0, pc_en}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 16'h0200, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("rw_redir", {31'd0, pc_redirect}, 32'd1);
    check("rw_tgt",   {16'd0, redirect_target}, 32'h0100);
    check("rw_wait",  {28'd0, wait_cycles}, 32'd3);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("rw_after_en", {31'd0, pc_en}, 32'd1);
    check("rw_after_tgt", {16'd0, redirect_target}, 32'h0100);

    // halt drains the outstanding access then stops for good
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check("h_en0", {31'd0, pc_en}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check("h_req1", {31'd0, imem_req}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("h_flush", {31'd0, ifid_flush}, 32'd1);
    check("h_en",    {31'd0, pc_en}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'h0050, 1'b0);
      check("h_halted", {31'd0, halted}, 32'd1);
      check("h_req0",   {31'd0, imem_req}, 32'd0);
      check("h_redir0", {31'd0, pc_redirect}, 32'd0);
    end

    // saturation of the 4-bit wait counter
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      if (i == 5) check("sat_mid", {28'd0, wait_cycles}, 32'd4);
    end
    check("sat_15", {28'd0, wait_cycles}, 32'd15);

    // asynchronous reset between edges
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("ar_pre_en", {31'd0, pc_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_en",   {31'd0, pc_en}, 32'd0);
    check("ar_req",  {31'd0, imem_req}, 32'd0);
    check("ar_we",   {31'd0, ifid_we}, 32'd0);
    check("ar_wait", {28'd0, wait_cycles}, 32'd0);
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("ar_resume_en", {31'd0, pc_en}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the 16-bit PC update datapath and the multi-cycle instruction memory.
- Issues fetch requests and decides each cycle whether the PC advances, holds or is redirected to a resolved branch target.
- Queues branch redirects that arrive while a fetch is in flight, and drains to a clean halted state on HLT.
- Sits between the fetch stage (PC updater, IMEM, IF/ID register) and the decode/hazard logic.

Parameters:
- ADDR_W, 16, PC and target width.
- CNT_W, 16, width of the saturating IMEM wait-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to IMEM at current PC.
- imem_ready  in  1  IMEM data valid this cycle for the current request.
- stall_id  in  1  decode hazard stall (load-use); hold PC and IF/ID.
- br_taken  in  1  resolved taken branch/jump this cycle.
- br_target  in  ADDR_W  target of br_taken.
- hlt_dec  in  1  HLT decoded this cycle.
- pc_en  out  1  PC updater advances at the next edge.
- pc_redirect  out  1  with pc_en, PC loads redirect_target instead of PC+2.
- redirect_target  out  ADDR_W  target to load.
- ifid_we  out  1  IF/ID register captures fetched instruction.
- ifid_flush  out  1  IF/ID register loads NOP.
- halted  out  1  fetch stopped permanently until reset.
- wait_cycles  out  CNT_W  count of FETCH cycles with imem_req=1 and imem_ready=0; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values, held while rst_n=0: state=BOOT, all 1-bit outputs 0, redirect_target=0, wait_cycles=0, pending redirect cleared.
- States:
  - BOOT: one cycle after rst_n rises, then FETCH.
  - FETCH: imem_req=1.
  - DRAIN: imem_req=1 until the outstanding access completes.
  - HALT: absorbing until reset.
- Output timing: pc_en, pc_redirect, ifid_we and ifid_flush are Mealy outputs, valid in the same cycle as their inputs. The PC updater and IF/ID register act on them at the next edge.
- FETCH, imem_ready=1, stall_id=0, no pending redirect, br_taken=0: pc_en=1, ifid_we=1, pc_redirect=0. PC+2 is fetched next cycle.
- FETCH, imem_ready=1, stall_id=1: pc_en=0, ifid_we=0, no flush. IMEM re-presents the same address. A stall never blocks a redirect (see next rule).
- br_taken=1 while imem_ready=1: pc_en=1, pc_redirect=1, redirect_target=br_target, ifid_flush=1, ifid_we=0.
- br_taken=1 while imem_ready=0:
  - Latch pend_valid=1 and pend_target=br_target.
  - When imem_ready is next 1: pc_en=1, pc_redirect=1, redirect_target=pend_target, ifid_flush=1; pend_valid clears at that edge.
- br_taken while pend_valid=1: ignored, because the requester is wrong-path.
- redirect_target holds its last driven value when pc_redirect=0.
- hlt_dec=1 with br_taken=0:
  - Go to DRAIN.
  - No further pc_en.
  - On imem_ready in DRAIN: ifid_flush=1, then HALT.
  - If imem_ready=1 in the same cycle as hlt_dec, go straight to HALT with ifid_flush=1.
- hlt_dec=1 with br_taken=1 in the same cycle: the branch wins and hlt_dec is dropped as wrong-path.
- hlt_dec while pend_valid=1: ignored.
- HALT: imem_req=0, pc_en=0, halted=1. All inputs ignored.
- wait_cycles increments only in FETCH/DRAIN with imem_req=1 and imem_ready=0. It stops at 2^CNT_W-1 and does not wrap.
- rst_n falling mid-access or mid-drain: immediate return to reset values; the pending redirect is lost.

Decomposition:
- Shared package holds:
  - state encoding constants: BOOT=2'b00, FETCH=2'b01, DRAIN=2'b10, HALT=2'b11.
  - ADDR_W default.
  - the NOP encoding used by the IF/ID flush.
- One sub-module, sat_counter (CNT_W wide, inc enable, async active-low clear), for wait_cycles. Everything else stays in fetch_ctrl.

Test Plan:
- Reset and boot: rst_n=0 then 1, imem_ready=1 → cycle 1 imem_req=0; from cycle 2 imem_req=1, pc_en=1 and ifid_we=1 every cycle; all outputs 0 during reset.
- Zero-wait redirect: imem_ready=1, br_taken=1, br_target=16'h0040 for one cycle → same cycle pc_en=1, pc_redirect=1, redirect_target=16'h0040, ifid_flush=1, ifid_we=0.
- Redirect during wait:
  - imem_ready=0 for 3 cycles; br_taken=1 (target 16'h0100) in the first of them; a second br_taken (16'h0200) in the second.
  - Expected: pc_redirect=1 with redirect_target=16'h0100 in the cycle imem_ready returns; the second branch is ignored; wait_cycles=3.
- Stall vs branch:
  - stall_id=1 with imem_ready=1 → pc_en=0, ifid_we=0.
  - stall_id=1 with br_taken=1 (target 16'h0008) → pc_redirect=1, pc_en=1.
- Halt:
  - hlt_dec=1 with imem_ready=0 for 2 cycles, then imem_ready=1 → ifid_flush=1 on the completing cycle, then halted=1 and imem_req=0 permanently.
  - hlt_dec together with br_taken → no halt, redirect taken.
- Saturation and async reset:
  - CNT_W=4, imem_ready=0 for 20 cycles → wait_cycles=15.
  - Assert rst_n=0 between edges → outputs 0 immediately, without waiting for clk.
